saturn_fetch_sequencer: RTL and testbench

//  Sequences the Saturn instruction decoder: owns PC, fetches nibbles over a req/ack nibble bus,

---
 rtl/saturn_fetch_sequencer_if.sv | 24 ++
 rtl/saturn_fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_saturn_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/saturn_fetch_sequencer_if.sv
// Nibble read bus between the Saturn fetch sequencer (master) and memory (slave).
// o_bus_req holds with a stable o_bus_addr until i_bus_ack; i_bus_nibble is valid only in the ack cycle.
interface saturn_fetch_sequencer_if #(
  parameter int ADDR_W = 20
);
  logic              o_bus_req;
  logic [ADDR_W-1:0] o_bus_addr;
  logic              i_bus_ack;
  logic [3:0]        i_bus_nibble;

  modport master (
    output o_bus_req,
    output o_bus_addr,
    input  i_bus_ack,
    input  i_bus_nibble
  );

  modport slave (
    input  o_bus_req,
    input  o_bus_addr,
    output i_bus_ack,
    output i_bus_nibble
  );
endinterface

// File: rtl/saturn_fetch_sequencer.sv
// Saturn fetch sequencer: owns the PC, fetches nibbles, strobes the decoder and the executor.
// Optional executed-instruction counter is enabled by defining SATURN_INSTR_CTR_EN.
module saturn_fetch_sequencer #(
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MAX_NIBBLES = 21,
  parameter int                CTR_W       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_run,
  output logic [CTR_W-1:0]       o_cycles,
  saturn_fetch_sequencer_if.master bus,
  output logic [3:0]             o_nibble,
  output logic                   o_en_dec,
  output logic                   o_instr_start,
  input  logic                   i_dec_continue,
  input  logic                   i_dec_done,
  output logic                   o_en_exec,
  input  logic                   i_exec_busy,
  input  logic                   i_pc_load,
  input  logic [ADDR_W-1:0]      i_pc_value,
  output logic [ADDR_W-1:0]      o_pc,
  output logic [4:0]             o_nib_count,
  output logic                   o_fault,
  output logic [CTR_W-1:0]       o_instr_ctr,
  output logic [2:0]             o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DEC    = 3'd2;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_EXWAIT = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       end_of_instr;

  // An instruction ends when execution is no longer stalled, either straight out of EXEC or EXWAIT.
  assign end_of_instr = ((state == S_EXEC) || (state == S_EXWAIT)) && !i_exec_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_run) state_nxt = S_FETCH;
      S_FETCH:  if (bus.i_bus_ack) state_nxt = S_DEC;
      S_DEC:    state_nxt = S_CHK;
      S_CHK: begin
        if (i_dec_done)
          state_nxt = S_EXEC;
        else if (i_dec_continue)
          state_nxt = (o_nib_count == 5'(MAX_NIBBLES)) ? S_FAULT : S_FETCH;
      end
      S_EXEC, S_EXWAIT: begin
        if (i_exec_busy)
          state_nxt = S_EXWAIT;
        else
          state_nxt = i_run ? S_FETCH : S_IDLE;
      end
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      o_pc        <= RESET_PC;
      o_cycles    <= '0;
      o_nib_count <= '0;
      o_nibble    <= '0;
      o_fault     <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_cycles <= o_cycles + CTR_W'(1);
      if (state_nxt == S_FAULT)
        o_fault <= 1'b1;
      case (state)
        S_IDLE: if (i_run) o_nib_count <= '0;
        S_FETCH: begin
          if (bus.i_bus_ack) begin
            o_nibble    <= bus.i_bus_nibble;
            o_pc        <= o_pc + ADDR_W'(1);
            o_nib_count <= o_nib_count + 5'd1;
          end
        end
        S_EXEC, S_EXWAIT: begin
          if (i_pc_load)
            o_pc <= i_pc_value;
          if (end_of_instr)
            o_nib_count <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SATURN_INSTR_CTR_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_instr_ctr <= '0;
    else if (state == S_EXEC)
      o_instr_ctr <= o_instr_ctr + CTR_W'(1);
  end
`else
  assign o_instr_ctr = '0;
`endif

  // Strobes decode straight from state so a reset drops the request on the very next edge.
  assign bus.o_bus_req  = (state == S_FETCH);
  assign bus.o_bus_addr = o_pc;
  assign o_en_dec       = (state == S_DEC);
  assign o_instr_start  = (state == S_DEC) && (o_nib_count == 5'd1);
  assign o_en_exec      = (state == S_EXEC);
  assign o_state        = state;

endmodule

// File: tb/tb_saturn_fetch_sequencer.sv
// Directed bench for saturn_fetch_sequencer; a second instance with RESET_PC=0xFFFFF checks PC wrap.
module tb_saturn_fetch_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_EXWAIT = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

`ifdef SATURN_INSTR_CTR_EN
  localparam bit CTR_EN = 1'b1;
`else
  localparam bit CTR_EN = 1'b0;
`endif

  // clock / reset
  logic i_clk;
  logic i_reset;
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  logic        i_run, ack, i_dec_continue, i_dec_done, i_exec_busy, i_pc_load;
  logic [3:0]  nib;
  logic [19:0] i_pc_value;

  saturn_fetch_sequencer_if #(.ADDR_W(20)) bus1 ();
  saturn_fetch_sequencer_if #(.ADDR_W(20)) bus2 ();
  assign bus1.i_bus_ack    = ack;
  assign bus1.i_bus_nibble = nib;
  assign bus2.i_bus_ack    = ack;
  assign bus2.i_bus_nibble = nib;

  logic [31:0] o_cycles, o_instr_ctr, w_cycles, w_instr_ctr;
  logic [3:0]  o_nibble, w_nibble;
  logic        o_en_dec, o_instr_start, o_en_exec, o_fault;
  logic        w_en_dec, w_instr_start, w_en_exec, w_fault;
  logic [19:0] o_pc, w_pc;
  logic [4:0]  o_nib_count, w_nib_count;
  logic [2:0]  o_state, w_state;

  saturn_fetch_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .o_cycles(o_cycles), .bus(bus1),
    .o_nibble(o_nibble), .o_en_dec(o_en_dec), .o_instr_start(o_instr_start),
    .i_dec_continue(i_dec_continue), .i_dec_done(i_dec_done), .o_en_exec(o_en_exec),
    .i_exec_busy(i_exec_busy), .i_pc_load(i_pc_load), .i_pc_value(i_pc_value),
    .o_pc(o_pc), .o_nib_count(o_nib_count), .o_fault(o_fault),
    .o_instr_ctr(o_instr_ctr), .o_state(o_state)
  );

  saturn_fetch_sequencer #(.RESET_PC(20'hFFFFF)) dut_wrap (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .o_cycles(w_cycles), .bus(bus2),
    .o_nibble(w_nibble), .o_en_dec(w_en_dec), .o_instr_start(w_instr_start),
    .i_dec_continue(i_dec_continue), .i_dec_done(i_dec_done), .o_en_exec(w_en_exec),
    .i_exec_busy(i_exec_busy), .i_pc_load(i_pc_load), .i_pc_value(i_pc_value),
    .o_pc(w_pc), .o_nib_count(w_nib_count), .o_fault(w_fault),
    .o_instr_ctr(w_instr_ctr), .o_state(w_state)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] cyc_exp  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; the reset value seen at the edge decides the expected cycle count.
  task automatic tick();
    logic r;
    r = i_reset;
    @(posedge i_clk);
    #1;
    cyc_exp = r ? 32'd0 : cyc_exp + 32'd1;
  endtask

  // From FETCH: ack one nibble, check the decode strobe, then answer the decoder in CHK.
  task automatic fetch_one(input logic [3:0] n, input logic first, input logic c, input logic d);
    ack = 1'b1;
    nib = n;
    tick();
    ack = 1'b0;
    check("en_dec", 32'(o_en_dec), 32'd1);
    check("instr_start", 32'(o_instr_start), 32'(first));
    check("nibble", 32'(o_nibble), 32'(n));
    i_dec_continue = c;
    i_dec_done     = d;
    tick();
    tick();
    i_dec_continue = 1'b0;
    i_dec_done     = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_run = 1'b0; ack = 1'b0; nib = 4'h0;
    i_dec_continue = 1'b0; i_dec_done = 1'b0; i_exec_busy = 1'b0;
    i_pc_load = 1'b0; i_pc_value = 20'h0;
    tick();
    tick();

    // reset state
    check("rst_state", 32'(o_state), 32'(S_IDLE));
    check("rst_pc", 32'(o_pc), 32'h00000);
    check("rst_pc_wrapdut", 32'(w_pc), 32'hFFFFF);
    check("rst_cycles", o_cycles, 32'd0);
    check("rst_req", 32'(bus1.o_bus_req), 32'd0);
    check("rst_strobes", {29'd0, o_en_dec, o_instr_start, o_en_exec}, 32'd0);
    check("rst_nib_count", 32'(o_nib_count), 32'd0);
    check("rst_nibble", 32'(o_nibble), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_instr_ctr", o_instr_ctr, 32'd0);
    i_reset = 1'b0;

    // single-nibble instruction, ack one cycle after req
    i_run = 1'b1;
    tick();
    check("t1_req", 32'(bus1.o_bus_req), 32'd1);
    check("t1_addr", 32'(bus1.o_bus_addr), 32'h00000);
    check("t1_addr_wrapdut", 32'(bus2.o_bus_addr), 32'hFFFFF);
    tick();
    check("t1_req_hold", 32'(bus1.o_bus_req), 32'd1);
    check("t1_cycles", o_cycles, cyc_exp);
    ack = 1'b1; nib = 4'h5;
    tick();
    ack = 1'b0;
    check("t1_en_dec", 32'(o_en_dec), 32'd1);
    check("t1_start", 32'(o_instr_start), 32'd1);
    check("t1_nibble", 32'(o_nibble), 32'h5);
    check("t1_pc", 32'(o_pc), 32'h00001);
    check("t1_nib_count", 32'(o_nib_count), 32'd1);
    check("t1_pc_wrap", 32'(w_pc), 32'h00000);
    i_dec_done = 1'b1;
    tick();
    check("t1_chk", 32'(o_state), 32'(S_CHK));
    check("t1_en_dec_off", 32'(o_en_dec), 32'd0);
    tick();
    i_dec_done = 1'b0;
    check("t1_en_exec", 32'(o_en_exec), 32'd1);
    check("t1_cycles_exec", o_cycles, 32'd5);
    tick();
    check("t1_en_exec_off", 32'(o_en_exec), 32'd0);
    check("t1_next_addr", 32'(bus1.o_bus_addr), 32'h00001);
    check("t1_nib_clr", 32'(o_nib_count), 32'd0);
    check("t1_instr_ctr", o_instr_ctr, CTR_EN ? 32'd1 : 32'd0);

    // three-nibble instruction, then stall with PC loads in EXWAIT
    fetch_one(4'hA, 1'b1, 1'b1, 1'b0);
    check("t2_refetch", 32'(o_state), 32'(S_FETCH));
    check("t2_addr2", 32'(bus1.o_bus_addr), 32'h00002);
    fetch_one(4'hB, 1'b0, 1'b1, 1'b0);
    fetch_one(4'hC, 1'b0, 1'b0, 1'b1);
    check("t2_en_exec", 32'(o_en_exec), 32'd1);
    check("t2_nib_count", 32'(o_nib_count), 32'd3);
    check("t2_pc", 32'(o_pc), 32'h00004);
    i_exec_busy = 1'b1;
    tick();
    check("t3_exwait", 32'(o_state), 32'(S_EXWAIT));
    check("t3_en_exec_off", 32'(o_en_exec), 32'd0);
    i_pc_load = 1'b1; i_pc_value = 20'h11111;
    tick();
    i_pc_load = 1'b0;
    check("t3_pc_load1", 32'(o_pc), 32'h11111);
    tick();
    check("t3_still_wait", 32'(o_state), 32'(S_EXWAIT));
    i_exec_busy = 1'b0; i_pc_load = 1'b1; i_pc_value = 20'h12345;
    tick();
    i_pc_load = 1'b0;
    check("t3_fetch", 32'(o_state), 32'(S_FETCH));
    check("t3_addr", 32'(bus1.o_bus_addr), 32'h12345);
    check("t3_nib_clr", 32'(o_nib_count), 32'd0);

    // PC load outside EXEC/EXWAIT is ignored
    i_pc_load = 1'b1; i_pc_value = 20'hABCDE;
    tick();
    i_pc_load = 1'b0;
    check("t4_load_ignored", 32'(o_pc), 32'h12345);

    // run drop mid-instruction: finish, then park
    i_run = 1'b0;
    fetch_one(4'h1, 1'b1, 1'b0, 1'b1);
    check("t5_en_exec", 32'(o_en_exec), 32'd1);
    tick();
    check("t5_idle", 32'(o_state), 32'(S_IDLE));
    check("t5_pc", 32'(o_pc), 32'h12346);
    tick();
    check("t5_no_req", 32'(bus1.o_bus_req), 32'd0);
    check("t5_instr_ctr", o_instr_ctr, CTR_EN ? 32'd3 : 32'd0);
    check("t5_cycles", o_cycles, cyc_exp);

    // 21 continues -> FAULT
    i_run = 1'b1;
    tick();
    for (int i = 0; i < 21; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      fetch_one(iv[3:0], (i == 0), 1'b1, 1'b0);
    end
    check("t6_state", 32'(o_state), 32'(S_FAULT));
    check("t6_fault", 32'(o_fault), 32'd1);
    check("t6_nib_count", 32'(o_nib_count), 32'd21);
    check("t6_pc", 32'(o_pc), 32'h1235B);
    check("t6_no_req", 32'(bus1.o_bus_req), 32'd0);
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    check("t6_frozen_pc", 32'(o_pc), 32'h1235B);
    check("t6_sticky", {30'd0, o_fault, bus1.o_bus_req}, 32'd2);
    check("t6_no_dec", 32'(o_en_dec), 32'd0);

    // reset during FETCH with ack withheld
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("t7_fault_clr", 32'(o_fault), 32'd0);
    tick();
    check("t7_req", 32'(bus1.o_bus_req), 32'd1);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; ack = 1'b1; i_run = 1'b0;
    check("t7_req_drop", 32'(bus1.o_bus_req), 32'd0);
    check("t7_pc", 32'(o_pc), 32'h00000);
    check("t7_cycles", o_cycles, 32'd0);
    tick();
    ack = 1'b0;
    check("t7_late_ack", 32'(o_state), 32'(S_IDLE));
    check("t7_nib_count", 32'(o_nib_count), 32'd0);
    check("t7_cycles1", o_cycles, cyc_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
